// File: rtl/l1d_data_ram_arb_pkg.sv
// Shared types and sizes for the L1D data RAM arbiter slice.
package l1d_data_ram_arb_pkg;

   localparam int unsigned L1D_INDEX_WIDTH     = 6;
   localparam int unsigned L1D_WAY_WIDTH       = 2;
   localparam int unsigned L1D_OFFSET_WIDTH    = 2;
   localparam int unsigned L1D_DATA_WIDTH      = 64;
   localparam int unsigned L1D_MSHR_ID_WIDTH   = 3;
   localparam int unsigned L1D_LOAD_ID_WIDTH   = 4;
   localparam int unsigned L1D_DATA_ADDR_WIDTH =
      L1D_INDEX_WIDTH + L1D_WAY_WIDTH + L1D_OFFSET_WIDTH;

   localparam logic [L1D_OFFSET_WIDTH-1:0] L1D_OFFSET_MAX = '1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Read-pipe id is wide enough for either a load id or an MSHR (evict) id.
   localparam int unsigned L1D_RD_ID_WIDTH = max_u(L1D_MSHR_ID_WIDTH, L1D_LOAD_ID_WIDTH);

   typedef struct packed {
      logic [L1D_INDEX_WIDTH-1:0]  index;
      logic [L1D_WAY_WIDTH-1:0]    way;
      logic [L1D_OFFSET_WIDTH-1:0] offset;
   } pack_data_addr;

   typedef struct packed {
      pack_data_addr               addr;
      logic [L1D_DATA_WIDTH-1:0]   data;
      logic [L1D_DATA_WIDTH/8-1:0] wstrb;
   } pack_data_wr_pld;

   typedef struct packed {
      pack_data_addr                addr;
      logic [L1D_LOAD_ID_WIDTH-1:0] load_id;
   } pack_data_rd_pld;

   typedef struct packed {
      pack_data_addr                evict_dat_addr;
      logic [L1D_MSHR_ID_WIDTH-1:0] evict_id;
   } pack_evict_dat_pld;

   typedef enum logic {RD_SRC_LOAD, RD_SRC_EVICT} rd_src_e;

   typedef struct packed {
      logic                       vld;
      rd_src_e                    src;
      logic [L1D_RD_ID_WIDTH-1:0] id;
   } rd_pipe_ent_t;

endpackage

// File: rtl/l1d_data_ram_arb_rd_pipe.sv
// Tracks in-flight SRAM reads: RAM_RD_LAT-deep shift of {vld,src,id}.
module l1d_data_ram_arb_rd_pipe
   import l1d_data_ram_arb_pkg::*;
#(
   parameter int unsigned RAM_RD_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_vld,
   input  rd_src_e                    in_src,
   input  logic [L1D_RD_ID_WIDTH-1:0] in_id,
   output logic                       out_vld,
   output rd_src_e                    out_src,
   output logic [L1D_RD_ID_WIDTH-1:0] out_id
);

   rd_pipe_ent_t pipe_q [RAM_RD_LAT];
   rd_pipe_ent_t pipe_d [RAM_RD_LAT];

   // Stage 0 captures the grant; each later stage takes its predecessor.
   always_comb begin
      pipe_d[0] = '{vld: in_vld, src: in_src, id: in_id};
      for (int i = 1; i < int'(RAM_RD_LAT); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Pipeline state; reset drops every in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(RAM_RD_LAT); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign out_vld = pipe_q[RAM_RD_LAT-1].vld;
   assign out_src = pipe_q[RAM_RD_LAT-1].src;
   assign out_id  = pipe_q[RAM_RD_LAT-1].id;

endmodule

// File: rtl/l1d_data_ram_arb.sv
// Single-port L1D data SRAM arbiter: one grant per cycle, read-return routing.
// Optional build macro L1D_DATA_ARB_AGING_EN adds starvation counters.
module l1d_data_ram_arb
   import l1d_data_ram_arb_pkg::*;
#(
   parameter int unsigned RAM_RD_LAT = 2
`ifdef L1D_DATA_ARB_AGING_EN
   ,
   parameter int unsigned AGE_MAX    = 15
`endif
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           refill_wr_vld,
   output logic                           refill_wr_rdy,
   input  pack_data_wr_pld                refill_wr_pld,
   input  logic                           load_rd_vld,
   output logic                           load_rd_rdy,
   input  pack_data_rd_pld                load_rd_pld,
   input  logic                           evict_dat_vld,
   output logic                           evict_dat_rdy,
   input  pack_evict_dat_pld              evict_dat_pld,
   input  logic                           store_wr_vld,
   output logic                           store_wr_rdy,
   input  pack_data_wr_pld                store_wr_pld,
   output logic                           ram_en,
   output logic                           ram_we,
   output logic [L1D_DATA_ADDR_WIDTH-1:0] ram_addr,
   output logic [L1D_DATA_WIDTH-1:0]      ram_wdata,
   output logic [L1D_DATA_WIDTH/8-1:0]    ram_wstrb,
   input  logic [L1D_DATA_WIDTH-1:0]      ram_rdata,
   output logic                           evict_rdat_vld,
   output logic [L1D_MSHR_ID_WIDTH-1:0]   evict_rdat_id,
   output logic [L1D_DATA_WIDTH-1:0]      evict_rdat_data,
   output logic                           load_rdat_vld,
   output logic [L1D_LOAD_ID_WIDTH-1:0]   load_rdat_id,
   output logic [L1D_DATA_WIDTH-1:0]      load_rdat_data
);

   logic gnt_refill, gnt_load, gnt_evict, gnt_store;
   logic evict_lock_q, evict_lock_d;

`ifdef L1D_DATA_ARB_AGING_EN
   localparam int unsigned   AGE_W   = $clog2(AGE_MAX + 1);
   localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

   logic [AGE_W-1:0] load_age_q, load_age_d;
   logic [AGE_W-1:0] evict_age_q, evict_age_d;
   logic [AGE_W-1:0] store_age_q, store_age_d;
   logic load_urg, evict_urg, store_urg;

   assign load_urg  = load_rd_vld   && (load_age_q  == AGE_SAT);
   assign evict_urg = evict_dat_vld && (evict_age_q == AGE_SAT);
   assign store_urg = store_wr_vld  && (store_age_q == AGE_SAT);
`endif

   // Grant select: refill first, then a locked evict line, then urgent, then base order.
   always_comb begin
      gnt_refill = 1'b0;
      gnt_load   = 1'b0;
      gnt_evict  = 1'b0;
      gnt_store  = 1'b0;
      if (rst) begin
         // no grants while in reset
      end else if (refill_wr_vld) begin
         gnt_refill = 1'b1;
      end else if (evict_lock_q && evict_dat_vld) begin
         gnt_evict = 1'b1;
`ifdef L1D_DATA_ARB_AGING_EN
      end else if (store_urg) begin
         gnt_store = 1'b1;
      end else if (evict_urg) begin
         gnt_evict = 1'b1;
      end else if (load_urg) begin
         gnt_load = 1'b1;
`endif
      end else if (load_rd_vld) begin
         gnt_load = 1'b1;
      end else if (evict_dat_vld) begin
         gnt_evict = 1'b1;
      end else if (store_wr_vld) begin
         gnt_store = 1'b1;
      end
   end

   assign refill_wr_rdy = gnt_refill;
   assign load_rd_rdy   = gnt_load;
   assign evict_dat_rdy = gnt_evict;
   assign store_wr_rdy  = gnt_store;

   // Drive the SRAM from the granted payload.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wstrb = '0;
      if (gnt_refill) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = refill_wr_pld.addr;
         ram_wdata = refill_wr_pld.data;
         ram_wstrb = refill_wr_pld.wstrb;
      end else if (gnt_store) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = store_wr_pld.addr;
         ram_wdata = store_wr_pld.data;
         ram_wstrb = store_wr_pld.wstrb;
      end else if (gnt_load) begin
         ram_en   = 1'b1;
         ram_addr = load_rd_pld.addr;
      end else if (gnt_evict) begin
         ram_en   = 1'b1;
         ram_addr = evict_dat_pld.evict_dat_addr;
      end
   end

   // Lock opens on beat 0 of a line and closes on its last beat.
   always_comb begin
      evict_lock_d = evict_lock_q;
      if (gnt_evict) begin
         if (evict_dat_pld.evict_dat_addr.offset == L1D_OFFSET_MAX) begin
            evict_lock_d = 1'b0;
         end else if (evict_dat_pld.evict_dat_addr.offset == '0) begin
            evict_lock_d = 1'b1;
         end
      end
   end

`ifdef L1D_DATA_ARB_AGING_EN
   // Lose counters: count waiting cycles, saturate, clear on handshake.
   always_comb begin
      load_age_d  = load_age_q;
      evict_age_d = evict_age_q;
      store_age_d = store_age_q;
      if (gnt_load)                                 load_age_d  = '0;
      else if (load_rd_vld && load_age_q != AGE_SAT) load_age_d  = load_age_q + 1'b1;
      if (gnt_evict)                                   evict_age_d = '0;
      else if (evict_dat_vld && evict_age_q != AGE_SAT) evict_age_d = evict_age_q + 1'b1;
      if (gnt_store)                                   store_age_d = '0;
      else if (store_wr_vld && store_age_q != AGE_SAT) store_age_d = store_age_q + 1'b1;
   end

   // Age counter state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_age_q  <= '0;
         evict_age_q <= '0;
         store_age_q <= '0;
      end else begin
         load_age_q  <= load_age_d;
         evict_age_q <= evict_age_d;
         store_age_q <= store_age_d;
      end
   end
`endif

   // Evict lock state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) evict_lock_q <= 1'b0;
      else     evict_lock_q <= evict_lock_d;
   end

   logic                       rd_in_vld, rd_out_vld;
   rd_src_e                    rd_in_src, rd_out_src;
   logic [L1D_RD_ID_WIDTH-1:0] rd_in_id, rd_out_id;

   assign rd_in_vld = gnt_load | gnt_evict;
   assign rd_in_src = gnt_evict ? RD_SRC_EVICT : RD_SRC_LOAD;
   assign rd_in_id  = gnt_evict ? L1D_RD_ID_WIDTH'(evict_dat_pld.evict_id)
                                : L1D_RD_ID_WIDTH'(load_rd_pld.load_id);

   l1d_data_ram_arb_rd_pipe #(
      .RAM_RD_LAT (RAM_RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (rd_in_vld),
      .in_src  (rd_in_src),
      .in_id   (rd_in_id),
      .out_vld (rd_out_vld),
      .out_src (rd_out_src),
      .out_id  (rd_out_id)
   );

   // Route the returning beat to its owner; outputs stay 0 when idle.
   always_comb begin
      evict_rdat_vld  = 1'b0;
      evict_rdat_id   = '0;
      evict_rdat_data = '0;
      load_rdat_vld   = 1'b0;
      load_rdat_id    = '0;
      load_rdat_data  = '0;
      if (rd_out_vld && rd_out_src == RD_SRC_EVICT) begin
         evict_rdat_vld  = 1'b1;
         evict_rdat_id   = rd_out_id[L1D_MSHR_ID_WIDTH-1:0];
         evict_rdat_data = ram_rdata;
      end else if (rd_out_vld) begin
         load_rdat_vld  = 1'b1;
         load_rdat_id   = rd_out_id[L1D_LOAD_ID_WIDTH-1:0];
         load_rdat_data = ram_rdata;
      end
   end

endmodule

// File: tb/tb_l1d_data_ram_arb.sv
// Randomized bench for l1d_data_ram_arb with a behavioural arbitration/RAM model.
`timescale 1ns/1ps
module tb_l1d_data_ram_arb;
   import l1d_data_ram_arb_pkg::*;

   localparam int unsigned LAT = 2;
`ifdef L1D_DATA_ARB_AGING_EN
   localparam int AGE_MAX = 15;
`endif
   localparam int R_REFILL = 0, R_LOAD = 1, R_EVICT = 2, R_STORE = 3;
   localparam int MEM_N = 1 << L1D_DATA_ADDR_WIDTH;

   logic clk = 1'b0;
   logic rst;
   logic refill_wr_vld, refill_wr_rdy, load_rd_vld, load_rd_rdy;
   logic evict_dat_vld, evict_dat_rdy, store_wr_vld, store_wr_rdy;
   pack_data_wr_pld   refill_wr_pld, store_wr_pld;
   pack_data_rd_pld   load_rd_pld;
   pack_evict_dat_pld evict_dat_pld;
   logic ram_en, ram_we;
   logic [L1D_DATA_ADDR_WIDTH-1:0] ram_addr;
   logic [L1D_DATA_WIDTH-1:0]      ram_wdata, ram_rdata;
   logic [L1D_DATA_WIDTH/8-1:0]    ram_wstrb;
   logic evict_rdat_vld, load_rdat_vld;
   logic [L1D_MSHR_ID_WIDTH-1:0] evict_rdat_id;
   logic [L1D_LOAD_ID_WIDTH-1:0] load_rdat_id;
   logic [L1D_DATA_WIDTH-1:0]    evict_rdat_data, load_rdat_data;

   l1d_data_ram_arb #(
      .RAM_RD_LAT (LAT)
`ifdef L1D_DATA_ARB_AGING_EN
      , .AGE_MAX  (AGE_MAX)
`endif
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .refill_wr_vld   (refill_wr_vld),
      .refill_wr_rdy   (refill_wr_rdy),
      .refill_wr_pld   (refill_wr_pld),
      .load_rd_vld     (load_rd_vld),
      .load_rd_rdy     (load_rd_rdy),
      .load_rd_pld     (load_rd_pld),
      .evict_dat_vld   (evict_dat_vld),
      .evict_dat_rdy   (evict_dat_rdy),
      .evict_dat_pld   (evict_dat_pld),
      .store_wr_vld    (store_wr_vld),
      .store_wr_rdy    (store_wr_rdy),
      .store_wr_pld    (store_wr_pld),
      .ram_en          (ram_en),
      .ram_we          (ram_we),
      .ram_addr        (ram_addr),
      .ram_wdata       (ram_wdata),
      .ram_wstrb       (ram_wstrb),
      .ram_rdata       (ram_rdata),
      .evict_rdat_vld  (evict_rdat_vld),
      .evict_rdat_id   (evict_rdat_id),
      .evict_rdat_data (evict_rdat_data),
      .load_rdat_vld   (load_rdat_vld),
      .load_rdat_id    (load_rdat_id),
      .load_rdat_data  (load_rdat_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Requester state held by the bench.
   bit                v [4];
   pack_data_wr_pld   refill_p, store_p;
   pack_data_rd_pld   load_p;
   pack_evict_dat_pld evict_p;
   pack_evict_dat_pld ev_line;   // current line being evicted; offset = next beat

   // Bench-side SRAM (what the DUT talks to) and the model's own view of memory.
   logic [L1D_DATA_WIDTH-1:0] ram_mem [MEM_N];
   logic [L1D_DATA_WIDTH-1:0] m_mem   [MEM_N];
   logic [L1D_DATA_WIDTH-1:0] rd_dly  [LAT];

   // Model state.
   bit m_lock;
`ifdef L1D_DATA_ARB_AGING_EN
   int m_age [4];
`endif
   typedef struct {
      int                        due;
      bit                        evict;
      int                        id;
      logic [L1D_DATA_WIDTH-1:0] data;
   } ret_t;
   ret_t q[$];

   function automatic pack_data_addr rand_addr();
      pack_data_addr a;
      a.index  = L1D_INDEX_WIDTH'($urandom_range(3));
      a.way    = L1D_WAY_WIDTH'($urandom);
      a.offset = L1D_OFFSET_WIDTH'($urandom);
      return a;
   endfunction

   task automatic new_line();
      ev_line.evict_dat_addr        = rand_addr();
      ev_line.evict_dat_addr.offset = '0;
      ev_line.evict_id              = L1D_MSHR_ID_WIDTH'($urandom);
   endtask

   task automatic drive();
      refill_wr_vld = v[R_REFILL];
      refill_wr_pld = refill_p;
      load_rd_vld   = v[R_LOAD];
      load_rd_pld   = load_p;
      evict_dat_vld = v[R_EVICT];
      evict_dat_pld = evict_p;
      store_wr_vld  = v[R_STORE];
      store_wr_pld  = store_p;
   endtask

   task automatic new_requests(input int p0, input int p1, input int p2, input int p3);
      if (!v[R_REFILL] && $urandom_range(99) < p0) begin
         v[R_REFILL] = 1;
         refill_p = '{addr: rand_addr(), data: {$urandom, $urandom}, wstrb: 8'hff};
      end
      if (!v[R_LOAD] && $urandom_range(99) < p1) begin
         v[R_LOAD] = 1;
         load_p = '{addr: rand_addr(), load_id: L1D_LOAD_ID_WIDTH'($urandom)};
      end
      if (!v[R_EVICT] && $urandom_range(99) < p2) begin
         v[R_EVICT] = 1;
         evict_p = ev_line;
      end
      if (!v[R_STORE] && $urandom_range(99) < p3) begin
         v[R_STORE] = 1;
         store_p = '{addr: rand_addr(), data: {$urandom, $urandom},
                     wstrb: L1D_DATA_WIDTH/8'($urandom)};
      end
   endtask

   // Which requester should win this cycle, from the stated priority rules.
   function automatic int model_pick();
      int order [4];
      if (v[R_REFILL]) return R_REFILL;
      if (m_lock && v[R_EVICT]) return R_EVICT;
`ifdef L1D_DATA_ARB_AGING_EN
      if (v[R_STORE] && m_age[R_STORE] == AGE_MAX) return R_STORE;
      if (v[R_EVICT] && m_age[R_EVICT] == AGE_MAX) return R_EVICT;
      if (v[R_LOAD]  && m_age[R_LOAD]  == AGE_MAX) return R_LOAD;
`endif
      order = m_lock ? '{R_REFILL, R_EVICT, R_LOAD, R_STORE}
                     : '{R_REFILL, R_LOAD, R_EVICT, R_STORE};
      foreach (order[k]) if (v[order[k]]) return order[k];
      return -1;
   endfunction

   // Bench SRAM behaviour, evaluated once per cycle after the checks.
   task automatic ram_step();
      for (int i = int'(LAT) - 1; i > 0; i--) rd_dly[i] = rd_dly[i-1];
      rd_dly[0] = {$urandom, $urandom};
      if (ram_en && !ram_we) rd_dly[0] = ram_mem[ram_addr];
      if (ram_en && ram_we) begin
         for (int b = 0; b < L1D_DATA_WIDTH / 8; b++)
            if (ram_wstrb[b]) ram_mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
      end
      ram_rdata = rd_dly[LAT-1];
   endtask

   task automatic check_returns();
      bit due;
      due = (q.size() > 0) && (q[0].due == cyc);
      check_eq("evict_rdat_vld", evict_rdat_vld, due && q[0].evict);
      check_eq("load_rdat_vld", load_rdat_vld, due && !q[0].evict);
      if (due) begin
         if (q[0].evict) begin
            check_eq("evict_rdat_id", evict_rdat_id, q[0].id);
            check_eq("evict_rdat_data", evict_rdat_data, q[0].data);
         end else begin
            check_eq("load_rdat_id", load_rdat_id, q[0].id);
            check_eq("load_rdat_data", load_rdat_data, q[0].data);
         end
         void'(q.pop_front());
      end
   endtask

   task automatic step(input int p0, input int p1, input int p2, input int p3);
      int                  w;
      pack_data_wr_pld     wp;
      logic [L1D_DATA_ADDR_WIDTH-1:0] a;
      @(negedge clk);
      w = model_pick();
      check_eq("refill_rdy", refill_wr_rdy, w == R_REFILL);
      check_eq("load_rdy", load_rd_rdy, w == R_LOAD);
      check_eq("evict_rdy", evict_dat_rdy, w == R_EVICT);
      check_eq("store_rdy", store_wr_rdy, w == R_STORE);
      check_eq("ram_en", ram_en, w >= 0);
      if (w == R_REFILL || w == R_STORE) begin
         wp = (w == R_REFILL) ? refill_p : store_p;
         check_eq("ram_we", ram_we, 1'b1);
         check_eq("ram_addr", ram_addr, wp.addr);
         check_eq("ram_wdata", ram_wdata, wp.data);
         check_eq("ram_wstrb", ram_wstrb, wp.wstrb);
         for (int b = 0; b < L1D_DATA_WIDTH / 8; b++)
            if (wp.wstrb[b]) m_mem[wp.addr][b*8 +: 8] = wp.data[b*8 +: 8];
      end else if (w == R_LOAD || w == R_EVICT) begin
         a = (w == R_LOAD) ? load_p.addr : evict_p.evict_dat_addr;
         check_eq("ram_we", ram_we, 1'b0);
         check_eq("ram_addr", ram_addr, a);
         q.push_back('{due: cyc + int'(LAT), evict: (w == R_EVICT),
                       id: (w == R_LOAD) ? int'(load_p.load_id) : int'(evict_p.evict_id),
                       data: m_mem[a]});
      end
      check_returns();
      ram_step();
`ifdef L1D_DATA_ARB_AGING_EN
      for (int k = R_LOAD; k <= R_STORE; k++) begin
         if (w == k)    m_age[k] = 0;
         else if (v[k]) m_age[k] = (m_age[k] < AGE_MAX) ? m_age[k] + 1 : AGE_MAX;
      end
`endif
      if (w == R_EVICT) begin
         if (evict_p.evict_dat_addr.offset == L1D_OFFSET_MAX) begin
            m_lock = 0;
            new_line();
         end else begin
            if (evict_p.evict_dat_addr.offset == '0) m_lock = 1;
            ev_line.evict_dat_addr.offset = ev_line.evict_dat_addr.offset + 1'b1;
         end
      end
      if (w >= 0) v[w] = 0;
      new_requests(p0, p1, p2, p3);
      @(posedge clk);
      #1;
      drive();
      cyc++;
   endtask

   // Reset with requests held: nothing may be granted or returned.
   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      repeat (ncyc) begin
         @(negedge clk);
         check_eq("rst_rdy", {refill_wr_rdy, load_rd_rdy, evict_dat_rdy, store_wr_rdy}, 4'b0);
         check_eq("rst_ram_en", ram_en, 1'b0);
         check_eq("rst_rdat_vld", {evict_rdat_vld, load_rdat_vld}, 2'b0);
         ram_step();
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b0;
      m_lock = 0;
`ifdef L1D_DATA_ARB_AGING_EN
      foreach (m_age[k]) m_age[k] = 0;
`endif
      q.delete();
   endtask

   initial begin
      for (int i = 0; i < MEM_N; i++) begin
         ram_mem[i] = {32'(i) * 32'h9e3779b9, ~32'(i)};
         m_mem[i]   = ram_mem[i];
      end
      foreach (rd_dly[i]) rd_dly[i] = '0;
      ram_rdata = '0;
      foreach (v[k]) v[k] = 0;
      refill_p = '0; store_p = '0; load_p = '0; evict_p = '0;
      new_line();
      m_lock = 0;
`ifdef L1D_DATA_ARB_AGING_EN
      foreach (m_age[k]) m_age[k] = 0;
`endif
      drive();
      do_reset(3);

      repeat (300) step(90, 90, 90, 90);   // dense contention
      repeat (200) step(30, 100, 100, 20); // evict lines against steady loads
      repeat (60)  step(0, 100, 0, 100);   // store held against back-to-back loads
      repeat (20)  step(90, 90, 90, 90);
      do_reset(3);                          // drops reads still in flight
      repeat (300) step(20, 30, 30, 30);   // sparse traffic
      repeat (100) step(60, 60, 60, 60);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
